// File: rtl/t02_pc_ctrl_if.sv
// Fetch/control bundle between the control unit and the PC controller.
// Pure wiring with no latency of its own; iready is the only flow-control signal.
interface t02_pc_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             enable;
    logic [5:0]       cu_op;
    logic [XLEN-1:0]  rs1_read;
    logic [XLEN-1:0]  imm;
    logic             alu_neg;
    logic             alu_zero;
    logic             iready;
    logic [XLEN-1:0]  pc_addr;
    logic             fetch_req;
    logic             halted;
    logic             trap;
    logic             trap_cause;
    logic [XLEN-1:0]  trap_addr;
    logic [CNT_W-1:0] instret;

    modport master (
        output enable, cu_op, rs1_read, imm, alu_neg, alu_zero, iready,
        input  pc_addr, fetch_req, halted, trap, trap_cause, trap_addr, instret
    );

    modport slave (
        input  enable, cu_op, rs1_read, imm, alu_neg, alu_zero, iready,
        output pc_addr, fetch_req, halted, trap, trap_cause, trap_addr, instret
    );
endinterface

// File: rtl/t02_pc_ctrl.sv
// PC controller with run/halt/trap FSM; next PC and counters update one cycle after iready.
// A low iready stalls the PC and the retired-instruction count; enable low parks in IDLE.
module t02_pc_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h3300_0000),
    parameter int              IALIGN    = 4,
    parameter int              OFF_SHIFT = 1,
    parameter int              CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    t02_pc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT, TRAP} state_t;

    localparam int              AB   = $clog2(IALIGN);
    localparam logic [XLEN-1:0] STEP = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] BOOT = RESET_VEC - STEP;

    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_ERROR = 6'd38;
    localparam logic [5:0] OP_HALT  = 6'd39;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cause_q, cause_d;
    logic [XLEN-1:0]  taddr_q, taddr_d;

    logic [XLEN-1:0]  seq_pc, rel_tgt, jalr_sum, tgt;
    logic             taken, misal;

    // Target selection: only redirected flow can be misaligned.
    always_comb begin
        seq_pc   = pc_q + STEP;
        rel_tgt  = pc_q + (bus.imm << OFF_SHIFT);
        jalr_sum = bus.rs1_read + bus.imm;
        taken    = 1'b0;
        case (bus.cu_op)
            OP_JAL:            taken = 1'b1;
            OP_JALR:           taken = 1'b1;
            OP_BEQ:            taken = bus.alu_zero;
            OP_BNE:            taken = ~bus.alu_zero;
            OP_BLT, OP_BLTU:   taken = bus.alu_neg;
            OP_BGE, OP_BGEU:   taken = ~bus.alu_neg | bus.alu_zero;
            default:           taken = 1'b0;
        endcase
        if (!taken)
            tgt = seq_pc;
        else if (bus.cu_op == OP_JALR)
            tgt = {jalr_sum[XLEN-1:1], 1'b0};
        else
            tgt = rel_tgt;
        misal = taken && (tgt[AB-1:0] != '0);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        taddr_d = taddr_q;
        if (!bus.enable) begin
            state_d = IDLE;
            pc_d    = BOOT;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (bus.iready) begin
                        if (bus.cu_op == OP_ERROR) begin
                            state_d = TRAP;
                            cause_d = 1'b1;
                            taddr_d = pc_q;
                        end else if (misal) begin
                            state_d = TRAP;
                            cause_d = 1'b0;
                            taddr_d = tgt;
                        end else if (bus.cu_op == OP_HALT) begin
                            state_d = HALT;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            pc_d    = tgt;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HALT:    state_d = HALT;
                TRAP:    state_d = TRAP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= BOOT;
            cnt_q   <= '0;
            cause_q <= 1'b0;
            taddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            taddr_q <= taddr_d;
        end
    end

    assign bus.pc_addr    = pc_q;
    assign bus.fetch_req  = (state_q == RUN);
    assign bus.halted     = (state_q == HALT);
    assign bus.trap       = (state_q == TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.trap_addr  = taddr_q;
    assign bus.instret    = cnt_q;
endmodule
